// File: rtl/hwacc_tcdm_arbiter.sv
// -----------------------------------------------------------------------------
// hwacc_tcdm_arbiter
//
// Round-robin arbiter between the hardware accelerators and the shared
// cluster TCDM ports. Port index j of every accelerator competes for shared
// TCDM port j. Lanes are independent. The TCDM response arrives exactly one
// cycle after the handshake. It is routed back to the accelerator that owned
// that handshake.
//
// Ports (accelerator-side buses are flattened with index a*N_PORTS+j):
//   clk_i, rst_i            clock and synchronous active-high reset
//   acc_req_i/add/wen/be/data  accelerator request channel
//   acc_gnt_o               grant, given only to the lane winner
//   acc_r_data_o            read data, broadcast to every accelerator
//   acc_r_valid_o           response valid, given only to the lane owner
//   tcdm_req/add/wen/be/data_o  shared TCDM request channel, one per lane
//   tcdm_gnt_i, tcdm_r_data_i, tcdm_r_valid_i  shared TCDM grant/response
//   xfer_cnt_o              saturating count of accepted transfers per lane
//   err_o                   sticky flag, set by a response with no transfer in flight
// -----------------------------------------------------------------------------
module hwacc_tcdm_arbiter #(
  parameter int N_HWACC = 3,
  parameter int N_PORTS = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [N_HWACC*N_PORTS-1:0]            acc_req_i,
  input  logic [N_HWACC*N_PORTS*ADDR_W-1:0]     acc_add_i,
  input  logic [N_HWACC*N_PORTS-1:0]            acc_wen_i,
  input  logic [N_HWACC*N_PORTS*(DATA_W/8)-1:0] acc_be_i,
  input  logic [N_HWACC*N_PORTS*DATA_W-1:0]     acc_data_i,
  output logic [N_HWACC*N_PORTS-1:0]            acc_gnt_o,
  output logic [N_HWACC*N_PORTS*DATA_W-1:0]     acc_r_data_o,
  output logic [N_HWACC*N_PORTS-1:0]            acc_r_valid_o,
  output logic [N_PORTS-1:0]                    tcdm_req_o,
  output logic [N_PORTS*ADDR_W-1:0]             tcdm_add_o,
  output logic [N_PORTS-1:0]                    tcdm_wen_o,
  output logic [N_PORTS*(DATA_W/8)-1:0]         tcdm_be_o,
  output logic [N_PORTS*DATA_W-1:0]             tcdm_data_o,
  input  logic [N_PORTS-1:0]                    tcdm_gnt_i,
  input  logic [N_PORTS*DATA_W-1:0]             tcdm_r_data_i,
  input  logic [N_PORTS-1:0]                    tcdm_r_valid_i,
  output logic [N_PORTS*CNT_W-1:0]              xfer_cnt_o,
  output logic                                  err_o
);

  localparam int NA    = N_HWACC * N_PORTS;
  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (N_HWACC > 1) ? $clog2(N_HWACC) : 1;

  logic [N_PORTS-1:0][IDX_W-1:0] rr_q, rr_d;
  logic [N_PORTS-1:0][IDX_W-1:0] own_q, own_d;
  logic [N_PORTS-1:0][IDX_W-1:0] win;
  logic [N_PORTS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [N_PORTS-1:0]            pend_q, pend_d;
  logic [N_PORTS-1:0]            hit;
  logic [N_PORTS-1:0]            hs;
  logic                          err_q, err_d;
  logic [NA-1:0]                 req_m;
  int                            idx;
  int                            nxt;

  // Requests are masked while reset is held, so nothing is granted in reset.
  assign req_m = acc_req_i & {NA{~rst_i}};

  always_comb begin
    rr_d          = rr_q;
    own_d         = own_q;
    cnt_d         = cnt_q;
    pend_d        = '0;
    err_d         = err_q;
    win           = '0;
    hit           = '0;
    hs            = '0;
    idx           = 0;
    nxt           = 0;
    acc_gnt_o     = '0;
    acc_r_valid_o = '0;
    acc_r_data_o  = '0;
    tcdm_req_o    = '0;
    tcdm_add_o    = '0;
    tcdm_wen_o    = '0;
    tcdm_be_o     = '0;
    tcdm_data_o   = '0;

    for (int j = 0; j < N_PORTS; j++) begin
      // The winner is the first requester at or above the pointer, wrapping around.
      for (int k = 0; k < N_HWACC; k++) begin
        idx = int'(rr_q[j]) + k;
        if (idx >= N_HWACC) idx = idx - N_HWACC;
        if (!hit[j] && req_m[idx*N_PORTS+j]) begin
          hit[j] = 1'b1;
          win[j] = IDX_W'(idx);
        end
      end

      if (hit[j]) begin
        idx = int'(win[j]) * N_PORTS + j;
        tcdm_req_o[j]                    = 1'b1;
        tcdm_add_o[j*ADDR_W +: ADDR_W]   = acc_add_i[idx*ADDR_W +: ADDR_W];
        tcdm_wen_o[j]                    = acc_wen_i[idx];
        tcdm_be_o[j*BE_W +: BE_W]        = acc_be_i[idx*BE_W +: BE_W];
        tcdm_data_o[j*DATA_W +: DATA_W]  = acc_data_i[idx*DATA_W +: DATA_W];
        acc_gnt_o[idx]                   = tcdm_gnt_i[j];
      end

      hs[j] = hit[j] & tcdm_gnt_i[j];
      if (hs[j]) begin
        nxt = int'(win[j]) + 1;
        if (nxt >= N_HWACC) nxt = 0;
        rr_d[j]   = IDX_W'(nxt);
        pend_d[j] = 1'b1;
        own_d[j]  = win[j];
        if (cnt_q[j] != {CNT_W{1'b1}}) cnt_d[j] = cnt_q[j] + CNT_W'(1);
      end

      // The response belongs to the handshake of the previous cycle. own_q holds
      // that owner even if a new handshake on this lane replaces own_d now.
      if (tcdm_r_valid_i[j]) begin
        if (pend_q[j]) begin
          if (!rst_i) acc_r_valid_o[int'(own_q[j])*N_PORTS+j] = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end

      for (int a = 0; a < N_HWACC; a++) begin
        acc_r_data_o[(a*N_PORTS+j)*DATA_W +: DATA_W] = tcdm_r_data_i[j*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q   <= '0;
      own_q  <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      rr_q   <= rr_d;
      own_q  <= own_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign xfer_cnt_o = cnt_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_hwacc_tcdm_arbiter.sv
module tb_hwacc_tcdm_arbiter;

  localparam int NH = 3;
  localparam int NP = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int CW = 4;
  localparam int NA = NH * NP;

  logic            clk = 1'b0;
  logic            rst;
  logic [NA-1:0]   acc_req, acc_wen;
  logic [NA*AW-1:0] acc_add;
  logic [NA*BW-1:0] acc_be;
  logic [NA*DW-1:0] acc_data;
  logic [NA-1:0]   acc_gnt_o, acc_r_valid_o;
  logic [NA*DW-1:0] acc_r_data_o;
  logic [NP-1:0]   tcdm_req_o, tcdm_wen_o, tcdm_gnt, tcdm_rv;
  logic [NP*AW-1:0] tcdm_add_o;
  logic [NP*BW-1:0] tcdm_be_o;
  logic [NP*DW-1:0] tcdm_data_o, tcdm_rdata;
  logic [NP*CW-1:0] xfer_cnt_o;
  logic            err_o;

  hwacc_tcdm_arbiter #(
    .N_HWACC(NH), .N_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .acc_req_i(acc_req), .acc_add_i(acc_add), .acc_wen_i(acc_wen),
    .acc_be_i(acc_be), .acc_data_i(acc_data),
    .acc_gnt_o(acc_gnt_o), .acc_r_data_o(acc_r_data_o), .acc_r_valid_o(acc_r_valid_o),
    .tcdm_req_o(tcdm_req_o), .tcdm_add_o(tcdm_add_o), .tcdm_wen_o(tcdm_wen_o),
    .tcdm_be_o(tcdm_be_o), .tcdm_data_o(tcdm_data_o),
    .tcdm_gnt_i(tcdm_gnt), .tcdm_r_data_i(tcdm_rdata), .tcdm_r_valid_i(tcdm_rv),
    .xfer_cnt_o(xfer_cnt_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference state: pointer, in-flight owner and counters per lane.
  int  rr_m [NP];
  int  own_m[NP];
  int  cnt_m[NP];
  bit  pend_m[NP];
  bit  err_m;
  logic [NA-1:0] last_gnt;

  typedef struct {
    int              cyc;
    logic [NA-1:0]   rv;
    logic [NA*DW-1:0] data;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int find_win(int j);
    for (int k = 0; k < NH; k++) begin
      int a;
      a = (rr_m[j] + k) % NH;
      if (acc_req[a*NP+j]) return a;
    end
    return -1;
  endfunction

  // One clock cycle: inputs already driven by the caller just after the edge.
  task automatic step();
    logic [NA-1:0]    e_gnt, e_rv;
    logic [NP-1:0]    e_req, e_wen;
    logic [NP*AW-1:0] e_add;
    logic [NP*BW-1:0] e_be;
    logic [NP*DW-1:0] e_data;
    logic [NP*CW-1:0] e_cnt;
    logic [NA*DW-1:0] e_rdata;
    int               w[NP];
    bit               e_err_n;
    exp_t             e;
    #1;
    e_gnt = '0; e_rv = '0; e_req = '0; e_wen = '0; e_add = '0; e_be = '0; e_data = '0;
    e_cnt = '0; e_rdata = '0; e_err_n = err_m;
    for (int j = 0; j < NP; j++) begin
      e_cnt[j*CW +: CW] = CW'(cnt_m[j]);
      w[j] = rst ? -1 : find_win(j);
      if (w[j] >= 0) begin
        int i;
        i = w[j] * NP + j;
        e_req[j]             = 1'b1;
        e_add[j*AW +: AW]    = acc_add[i*AW +: AW];
        e_wen[j]             = acc_wen[i];
        e_be[j*BW +: BW]     = acc_be[i*BW +: BW];
        e_data[j*DW +: DW]   = acc_data[i*DW +: DW];
        e_gnt[i]             = tcdm_gnt[j];
      end
      if (!rst && tcdm_rv[j]) begin
        if (pend_m[j]) e_rv[own_m[j]*NP+j] = 1'b1;
        else e_err_n = 1'b1;
      end
      for (int a = 0; a < NH; a++) e_rdata[(a*NP+j)*DW +: DW] = tcdm_rdata[j*DW +: DW];
    end
    chk("xfer_cnt", 512'(xfer_cnt_o), 512'(e_cnt));
    chk("err", 512'(err_o), 512'(err_m));
    chk("tcdm_req", 512'(tcdm_req_o), 512'(e_req));
    chk("acc_gnt", 512'(acc_gnt_o), 512'(e_gnt));
    chk("tcdm_add", 512'(tcdm_add_o), 512'(e_add));
    chk("tcdm_wen", 512'(tcdm_wen_o), 512'(e_wen));
    chk("tcdm_be", 512'(tcdm_be_o), 512'(e_be));
    chk("tcdm_data", 512'(tcdm_data_o), 512'(e_data));
    if (e_rv != '0) begin
      e.cyc = cyc; e.rv = e_rv; e.data = e_rdata;
      sb.push_back(e);
    end
    last_gnt = e_gnt;
    @(posedge clk);
    if (rst) begin
      for (int j = 0; j < NP; j++) begin
        rr_m[j] = 0; own_m[j] = 0; cnt_m[j] = 0; pend_m[j] = 0;
      end
      err_m = 0;
    end else begin
      for (int j = 0; j < NP; j++) begin
        if (w[j] >= 0 && tcdm_gnt[j]) begin
          rr_m[j]   = (w[j] + 1) % NH;
          pend_m[j] = 1;
          own_m[j]  = w[j];
          if (cnt_m[j] < (1 << CW) - 1) cnt_m[j]++;
        end else begin
          pend_m[j] = 0;
        end
      end
      err_m = e_err_n;
    end
    #1;
  endtask

  // Response monitor: every r_valid the DUT shows must match the oldest expectation.
  always @(negedge clk) begin
    if (acc_r_valid_o != '0) begin
      if (sb.size() == 0) begin
        chk("rvalid_unexpected", 512'(acc_r_valid_o), 512'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rvalid_cycle", 512'(cyc), 512'(e.cyc));
        chk("rvalid_route", 512'(acc_r_valid_o), 512'(e.rv));
        chk("rdata", 512'(acc_r_data_o), 512'(e.data));
      end
    end
  end

  task automatic idle_inputs();
    acc_req = '0; acc_wen = '0; acc_add = '0; acc_be = '0; acc_data = '0;
    tcdm_gnt = '0; tcdm_rv = '0; tcdm_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic set_acc(input int a, input int j, input logic [AW-1:0] addr,
                         input logic wen, input logic [DW-1:0] data);
    int i;
    i = a * NP + j;
    acc_req[i] = 1'b1;
    acc_add[i*AW +: AW] = addr;
    acc_wen[i] = wen;
    acc_be[i*BW +: BW] = '1;
    acc_data[i*DW +: DW] = data;
  endtask

  initial begin
    for (int j = 0; j < NP; j++) begin
      rr_m[j] = 0; own_m[j] = 0; cnt_m[j] = 0; pend_m[j] = 0;
    end
    err_m = 0;
    last_gnt = '0;
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    step();
    step();
    rst = 1'b0;

    // Single requester: accelerator 1, lane 0, read of 0x100.
    set_acc(1, 0, 32'h100, 1'b1, 32'h0);
    tcdm_gnt = 3'b001;
    #1;
    chk("single_add", 512'(tcdm_add_o[AW-1:0]), 512'(32'h100));
    chk("single_gnt", 512'(acc_gnt_o), 512'(9'b000_001_000));
    step();
    idle_inputs();
    tcdm_rv = 3'b001;
    tcdm_rdata[DW-1:0] = 32'hCAFE;
    step();
    idle_inputs();
    #1;
    chk("single_cnt", 512'(xfer_cnt_o[CW-1:0]), 512'(1));
    step();

    // Three accelerators on lane 2, grant always high: order 0,1,2,0,1,2.
    do_reset();
    for (int c = 0; c < 6; c++) begin
      idle_inputs();
      for (int a = 0; a < NH; a++) set_acc(a, 2, 32'h2000 + 32'(a), 1'b0, 32'hA0 + 32'(a));
      tcdm_gnt = 3'b100;
      tcdm_rv  = (c > 0) ? 3'b100 : 3'b000;
      tcdm_rdata[2*DW +: DW] = 32'h5500 + 32'(c);
      #1;
      chk("rr_order", 512'(acc_gnt_o), 512'(9'(1) << ((c % 3) * NP + 2)));
      step();
    end
    idle_inputs();
    tcdm_rv = 3'b100;
    step();

    // Lane 1 stalled by gnt=0 for 4 cycles, then accelerator 0, then 2.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      idle_inputs();
      set_acc(0, 1, 32'h10, 1'b1, 32'h0);
      set_acc(2, 1, 32'h30, 1'b0, 32'h33);
      #1;
      chk("stall_nognt", 512'(acc_gnt_o), 512'(0));
      step();
    end
    tcdm_gnt = 3'b010;
    #1;
    chk("stall_first", 512'(acc_gnt_o), 512'(9'b000_000_010));
    step();
    tcdm_rv = 3'b010;
    #1;
    chk("stall_second", 512'(acc_gnt_o), 512'(9'b010_000_000));
    step();
    idle_inputs();
    tcdm_rv = 3'b010;
    step();

    // Simultaneous handshakes on lanes 0 and 1 from different accelerators.
    do_reset();
    set_acc(0, 0, 32'h400, 1'b1, 32'h0);
    set_acc(2, 1, 32'h800, 1'b0, 32'hBEEF);
    tcdm_gnt = 3'b011;
    step();
    idle_inputs();
    tcdm_rv = 3'b011;
    tcdm_rdata = {32'h0, 32'h1111, 32'h2222};
    step();
    idle_inputs();
    #1;
    chk("dual_cnt", 512'(xfer_cnt_o), 512'({4'd0, 4'd1, 4'd1}));
    step();

    // Orphan response on lane 0.
    do_reset();
    tcdm_rv = 3'b001;
    step();
    idle_inputs();
    #1;
    chk("orphan_err", 512'(err_o), 512'(1));
    step();
    step();
    #1;
    chk("orphan_sticky", 512'(err_o), 512'(1));

    // Reset right after a handshake; response in the first post-reset cycle.
    do_reset();
    set_acc(0, 0, 32'h40, 1'b1, 32'h0);
    tcdm_gnt = 3'b001;
    step();
    idle_inputs();
    rst = 1'b1;
    tcdm_rv = 3'b001;
    step();
    rst = 1'b0;
    tcdm_rv = 3'b001;
    step();
    idle_inputs();
    #1;
    chk("rst_orphan_err", 512'(err_o), 512'(1));
    chk("rst_cnt", 512'(xfer_cnt_o), 512'(0));
    step();

    // Counter saturation: 20 handshakes on lane 0.
    do_reset();
    for (int c = 0; c < 20; c++) begin
      idle_inputs();
      set_acc(c % NH, 0, 32'(c), 1'b1, 32'h0);
      tcdm_gnt = 3'b001;
      tcdm_rv  = (c > 0) ? 3'b001 : 3'b000;
      step();
    end
    idle_inputs();
    tcdm_rv = 3'b001;
    step();
    #1;
    chk("cnt_saturate", 512'(xfer_cnt_o[CW-1:0]), 512'(15));

    // Randomised traffic; requesters hold their request until granted.
    do_reset();
    last_gnt = '0;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(99) == 0);
      for (int i = 0; i < NA; i++) begin
        if (!(acc_req[i] && !last_gnt[i])) begin
          acc_req[i]           = 1'($urandom_range(1));
          acc_add[i*AW +: AW]  = $urandom;
          acc_wen[i]           = 1'($urandom_range(1));
          acc_be[i*BW +: BW]   = BW'($urandom);
          acc_data[i*DW +: DW] = $urandom;
        end
      end
      for (int j = 0; j < NP; j++) begin
        tcdm_gnt[j] = ($urandom_range(3) != 0);
        tcdm_rv[j]  = pend_m[j] || ($urandom_range(49) == 0);
        tcdm_rdata[j*DW +: DW] = $urandom;
      end
      step();
    end
    rst = 1'b0;
    idle_inputs();
    step();
    step();

    @(negedge clk);
    #1;
    chk("sb_drained", 512'(sb.size()), 512'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
